// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locking arbiter: shares one registered valid/ready/last stream
// among NUM_REQ requester streams and tags each output beat with its source index.
module stream_rr_arbiter #(
   parameter int DATA_WD     = 4,
   parameter int NUM_REQ     = 4,
   parameter bit LOCK_PACKET = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             s_valid,
   input  logic [NUM_REQ-1:0]             s_last,
   input  logic [NUM_REQ*DATA_WD-1:0]     s_data,
   output logic [NUM_REQ-1:0]             s_ready,
   output logic                           m_valid,
   output logic                           m_last,
   output logic [DATA_WD-1:0]             m_data,
   output logic [$clog2(NUM_REQ)-1:0]     m_id,
   input  logic                           m_ready
);

   localparam int ID_WD = $clog2(NUM_REQ);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t               state_q;
   logic [ID_WD-1:0]     grant_q;
   logic [ID_WD-1:0]     rr_ptr_q;
   logic                 m_valid_q;
   logic                 m_last_q;
   logic [DATA_WD-1:0]   m_data_q;
   logic [ID_WD-1:0]     m_id_q;

   logic [ID_WD-1:0]     winner_d;
   logic [ID_WD-1:0]     rr_ptr_d;
   logic [DATA_WD-1:0]   grant_data;
   logic                 slot_free;
   logic                 grant_fire;
   logic                 pkt_done;

   // Output register can accept a beat when empty or when it is draining this cycle.
   assign slot_free  = !m_valid_q || m_ready;
   assign grant_fire = (state_q == ST_BUSY) && slot_free && s_valid[grant_q];
   assign pkt_done   = grant_fire && (s_last[grant_q] || !LOCK_PACKET);
   assign grant_data = s_data[grant_q*DATA_WD +: DATA_WD];
   assign rr_ptr_d   = (grant_q == ID_WD'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

   // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      logic found;
      int   idx;
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      winner_d = rr_ptr_q;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && s_valid[idx]) begin
            winner_d = ID_WD'(idx);
            found    = 1'b1;
         end
      end
   end

   // Ready is a function of state and downstream ready only, never of s_valid.
   always_comb begin
      s_ready = '0;
      if (state_q == ST_BUSY && slot_free) begin
         s_ready[grant_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         m_id_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            ST_IDLE: begin
               if (|s_valid) begin
                  grant_q <= winner_d;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (pkt_done) begin
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (grant_fire) begin
            m_valid_q <= 1'b1;
            m_data_q  <= grant_data;
            m_last_q  <= s_last[grant_q];
            m_id_q    <= grant_q;
         end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;
   assign m_id    = m_id_q;

endmodule
